// File: rtl/fetch_stage_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
//   Shared types and constants for the instruction-fetch stage.
//   fetch_state_t : fetch FSM state (REQ, WAIT, DROP, HOLD)
//   NOP_INSTR     : bubble instruction (addi x0,x0,0) driven when no valid fetch
// -----------------------------------------------------------------------------
package fetch_pkg;

   typedef enum logic [1:0] {
      REQ,   // issuing a request at pc_q
      WAIT,  // request accepted, awaiting its response
      DROP,  // stale request outstanding after a redirect; discard its response
      HOLD   // response captured while stalled; presenting hold_q
   } fetch_state_t;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/fetch_stage_if.sv
// -----------------------------------------------------------------------------
// fetch_stage_if
//   Instruction-memory request/response channel.
//   imem_req    : request valid (fetch -> memory)
//   imem_addr   : word-aligned request address (fetch -> memory)
//   imem_ready  : memory accepts the request this cycle (memory -> fetch)
//   imem_rvalid : response valid (memory -> fetch)
//   imem_rdata  : response instruction word (memory -> fetch)
//   Modports: master = fetch stage, slave = instruction memory.
// -----------------------------------------------------------------------------
interface fetch_stage_if #(
   parameter int unsigned DATA_WIDTH = 32
);

   logic                  imem_req;
   logic [DATA_WIDTH-1:0] imem_addr;
   logic                  imem_ready;
   logic                  imem_rvalid;
   logic [DATA_WIDTH-1:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ready,
      input  imem_rvalid,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ready,
      output imem_rvalid,
      output imem_rdata
   );

endinterface

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//   Instruction-fetch stage of the RV32I pipeline. Owns the PC, keeps at most
//   one instruction-memory request outstanding, handles stalls and redirects
//   from Execute, and drives a NOP bubble whenever no valid instruction exists.
//
//   clk, rst      : clock; synchronous active-high reset
//   stallF        : hold the presented instruction and PC
//   PCSrcE        : redirect to PCTargetE this cycle (beats stall and hand-off)
//   PCTargetE     : redirect target (low two bits ignored)
//   imem          : instruction-memory channel (master side)
//   PCounterF     : PC of the presented instruction
//   instr         : fetched instruction, or NOP_INSTR when not valid
//   PCPlus4F      : PCounterF + 4 (wraps)
//   fetch_validF  : instr is a real fetched instruction this cycle
// -----------------------------------------------------------------------------
module fetch_stage #(
   parameter int unsigned           DATA_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0,
   parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = DATA_WIDTH'(fetch_pkg::NOP_INSTR)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  stallF,
   input  logic                  PCSrcE,
   input  logic [DATA_WIDTH-1:0] PCTargetE,
   fetch_stage_if.master         imem,
   output logic [DATA_WIDTH-1:0] PCounterF,
   output logic [DATA_WIDTH-1:0] instr,
   output logic [DATA_WIDTH-1:0] PCPlus4F,
   output logic                  fetch_validF
);

   import fetch_pkg::*;

   localparam logic [DATA_WIDTH-1:0] PC_STEP = DATA_WIDTH'(4);

   fetch_state_t          state_q, state_d;
   logic [DATA_WIDTH-1:0] pc_q, pc_d;
   logic [DATA_WIDTH-1:0] hold_q, hold_d;
   logic [DATA_WIDTH-1:0] target;
   logic                  resp;
   logic                  unused_target_lsbs;

   assign target             = {PCTargetE[DATA_WIDTH-1:2], 2'b00};
   assign unused_target_lsbs = ^PCTargetE[1:0];

   // A response for the current PC arrives this cycle: either in WAIT, or in
   // REQ when the memory accepts and answers in the same cycle.
   assign resp = imem.imem_rvalid &&
                 ((state_q == WAIT) || ((state_q == REQ) && imem.imem_ready));

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= REQ;
         pc_q    <= RESET_PC;
         hold_q  <= NOP_INSTR;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         hold_q  <= hold_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      hold_d  = hold_q;
      case (state_q)
         REQ, WAIT: begin
            if (resp) begin
               if (PCSrcE) begin
                  pc_d    = target;
                  state_d = REQ;
               end else if (!stallF) begin
                  pc_d    = pc_q + PC_STEP;
                  state_d = REQ;
               end else begin
                  hold_d  = imem.imem_rdata;
                  state_d = HOLD;
               end
            end else if ((state_q == WAIT) || imem.imem_ready) begin
               // Request in flight with no data yet; a redirect must still
               // swallow the response that belongs to the old PC.
               if (PCSrcE) begin
                  pc_d    = target;
                  state_d = DROP;
               end else begin
                  state_d = WAIT;
               end
            end else if (PCSrcE) begin
               pc_d = target;
            end
         end
         HOLD: begin
            if (PCSrcE) begin
               pc_d    = target;
               state_d = REQ;
            end else if (!stallF) begin
               pc_d    = pc_q + PC_STEP;
               state_d = REQ;
            end
         end
         DROP: begin
            if (PCSrcE) begin
               pc_d = target;
            end
            if (imem.imem_rvalid) begin
               state_d = REQ;
            end
         end
         default: state_d = REQ;
      endcase
   end

   // Output logic
   always_comb begin
      imem.imem_req = 1'b0;
      fetch_validF  = 1'b0;
      instr         = NOP_INSTR;
      if (!rst) begin
         imem.imem_req = (state_q == REQ);
         if (!PCSrcE) begin
            if (state_q == HOLD) begin
               fetch_validF = 1'b1;
               instr        = hold_q;
            end else if (resp) begin
               fetch_validF = 1'b1;
               instr        = imem.imem_rdata;
            end
         end
      end
   end

   assign imem.imem_addr = pc_q;
   assign PCounterF      = rst ? RESET_PC : pc_q;
   assign PCPlus4F       = PCounterF + PC_STEP;

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//   Directed bench for fetch_stage. A small instruction-memory responder with
//   configurable latency returns addr ^ 32'hA5A5_0000 for every request.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam logic [31:0] KEY = 32'hA5A5_0000;

   logic        clk;
   logic        rst;
   logic        stallF;
   logic        PCSrcE;
   logic [31:0] PCTargetE;
   logic [31:0] PCounterF;
   logic [31:0] instr;
   logic [31:0] PCPlus4F;
   logic        fetch_validF;

   int passed = 0;
   int total  = 0;

   fetch_stage_if #(.DATA_WIDTH(32)) bus ();

   fetch_stage #(
      .DATA_WIDTH (32),
      .RESET_PC   (32'h0000_0000),
      .NOP_INSTR  (NOP)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .stallF       (stallF),
      .PCSrcE       (PCSrcE),
      .PCTargetE    (PCTargetE),
      .imem         (bus),
      .PCounterF    (PCounterF),
      .instr        (instr),
      .PCPlus4F     (PCPlus4F),
      .fetch_validF (fetch_validF)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory responder: lat==0 answers in the accepting cycle, otherwise the
   // response appears lat cycles after acceptance.
   int          lat = 0;
   int          cnt = 0;
   logic [31:0] lat_addr = '0;

   always @(posedge clk) begin
      if (rst) begin
         cnt <= 0;
      end else if (lat > 0 && bus.imem_req && bus.imem_ready) begin
         cnt      <= lat;
         lat_addr <= bus.imem_addr;
      end else if (cnt > 0) begin
         cnt <= cnt - 1;
      end
   end

   assign bus.imem_ready  = 1'b1;
   assign bus.imem_rvalid = (lat == 0) ? (bus.imem_req && bus.imem_ready) : (cnt == 1);
   assign bus.imem_rdata  = ((lat == 0) ? bus.imem_addr : lat_addr) ^ KEY;

   task automatic reset_dut(input int l);
      @(negedge clk);
      rst = 1'b1; stallF = 1'b0; PCSrcE = 1'b0; PCTargetE = '0; lat = l;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset;
      @(negedge clk);
      rst = 1'b1; stallF = 1'b0; PCSrcE = 1'b0; PCTargetE = '0; lat = 0;
      @(negedge clk); #1;
      total++; if (bus.imem_req !== 1'b0) $display("FAIL rst_req got=%b exp=0", bus.imem_req); else passed++;
      total++; if (instr !== NOP) $display("FAIL rst_instr got=%h exp=%h", instr, NOP); else passed++;
      total++; if (fetch_validF !== 1'b0) $display("FAIL rst_valid got=%b exp=0", fetch_validF); else passed++;
      total++; if (PCounterF !== 32'h0) $display("FAIL rst_pc got=%h exp=0", PCounterF); else passed++;
      total++; if (PCPlus4F !== 32'h4) $display("FAIL rst_pc4 got=%h exp=4", PCPlus4F); else passed++;
   endtask

   task automatic test_zero_latency;
      logic [31:0] e;
      reset_dut(0);
      for (int i = 0; i < 6; i++) begin
         #1;
         e = 32'(4 * i);
         total++; if (fetch_validF !== 1'b1) $display("FAIL zl_valid cyc=%0d got=%b exp=1", i, fetch_validF); else passed++;
         total++; if (PCounterF !== e) $display("FAIL zl_pc cyc=%0d got=%h exp=%h", i, PCounterF, e); else passed++;
         total++; if (instr !== (e ^ KEY)) $display("FAIL zl_instr cyc=%0d got=%h exp=%h", i, instr, e ^ KEY); else passed++;
         @(negedge clk);
      end
   endtask

   task automatic test_latency2;
      logic [31:0] e_pc;
      logic        e_v;
      logic [31:0] e_i;
      reset_dut(2);
      for (int i = 0; i < 9; i++) begin
         #1;
         e_pc = 32'(4 * (i / 3));
         e_v  = (i % 3 == 2);
         e_i  = e_v ? (e_pc ^ KEY) : NOP;
         total++; if (fetch_validF !== e_v) $display("FAIL l2_valid cyc=%0d got=%b exp=%b", i, fetch_validF, e_v); else passed++;
         total++; if (PCounterF !== e_pc) $display("FAIL l2_pc cyc=%0d got=%h exp=%h", i, PCounterF, e_pc); else passed++;
         total++; if (instr !== e_i) $display("FAIL l2_instr cyc=%0d got=%h exp=%h", i, instr, e_i); else passed++;
         @(negedge clk);
      end
   endtask

   task automatic test_stall;
      logic [31:0] e_pc;
      logic        e_req;
      reset_dut(0);
      for (int i = 0; i < 9; i++) begin
         stallF = (i >= 4 && i <= 6);
         #1;
         e_pc  = (i <= 3) ? 32'(4 * i) : (i <= 7) ? 32'h10 : 32'h14;
         e_req = !(i >= 5 && i <= 7);
         total++; if (fetch_validF !== 1'b1) $display("FAIL st_valid cyc=%0d got=%b exp=1", i, fetch_validF); else passed++;
         total++; if (PCounterF !== e_pc) $display("FAIL st_pc cyc=%0d got=%h exp=%h", i, PCounterF, e_pc); else passed++;
         total++; if (instr !== (e_pc ^ KEY)) $display("FAIL st_instr cyc=%0d got=%h exp=%h", i, instr, e_pc ^ KEY); else passed++;
         total++; if (bus.imem_req !== e_req) $display("FAIL st_req cyc=%0d got=%b exp=%b", i, bus.imem_req, e_req); else passed++;
         if (e_req) begin
            total++; if (bus.imem_addr !== e_pc) $display("FAIL st_addr cyc=%0d got=%h exp=%h", i, bus.imem_addr, e_pc); else passed++;
         end
         @(negedge clk);
      end
      stallF = 1'b0;
   endtask

   task automatic test_redirect_inflight;
      logic [31:0] e_pc;
      logic        e_v;
      logic        e_req;
      reset_dut(2);
      for (int i = 0; i < 6; i++) begin
         PCSrcE    = (i == 1);
         PCTargetE = 32'h0000_0103;
         #1;
         e_pc  = (i <= 1) ? 32'h0 : 32'h100;
         e_v   = (i == 5);
         e_req = (i == 0 || i == 3);
         total++; if (fetch_validF !== e_v) $display("FAIL rd_valid cyc=%0d got=%b exp=%b", i, fetch_validF, e_v); else passed++;
         total++; if (PCounterF !== e_pc) $display("FAIL rd_pc cyc=%0d got=%h exp=%h", i, PCounterF, e_pc); else passed++;
         total++; if (instr !== (e_v ? 32'hA5A5_0100 : NOP)) $display("FAIL rd_instr cyc=%0d got=%h", i, instr); else passed++;
         total++; if (bus.imem_req !== e_req) $display("FAIL rd_req cyc=%0d got=%b exp=%b", i, bus.imem_req, e_req); else passed++;
         @(negedge clk);
      end
      PCSrcE = 1'b0;
   endtask

   task automatic test_redirect_over_stall;
      reset_dut(0);
      stallF = 1'b1; PCSrcE = 1'b0;
      #1;
      total++; if (instr !== 32'hA5A5_0000) $display("FAIL rs_first_instr got=%h exp=a5a50000", instr); else passed++;
      @(negedge clk);
      stallF = 1'b1; PCSrcE = 1'b1; PCTargetE = 32'h0000_0040;
      #1;
      total++; if (fetch_validF !== 1'b0) $display("FAIL rs_valid got=%b exp=0", fetch_validF); else passed++;
      total++; if (instr !== NOP) $display("FAIL rs_instr got=%h exp=%h", instr, NOP); else passed++;
      @(negedge clk);
      stallF = 1'b0; PCSrcE = 1'b0;
      #1;
      total++; if (PCounterF !== 32'h40) $display("FAIL rs_pc got=%h exp=40", PCounterF); else passed++;
      total++; if (instr !== 32'hA5A5_0040) $display("FAIL rs_tgt_instr got=%h exp=a5a50040", instr); else passed++;
      total++; if (fetch_validF !== 1'b1) $display("FAIL rs_tgt_valid got=%b exp=1", fetch_validF); else passed++;
      @(negedge clk);
      #1;
      total++; if (PCounterF !== 32'h44) $display("FAIL rs_next_pc got=%h exp=44", PCounterF); else passed++;
   endtask

   task automatic test_pc_wrap;
      reset_dut(0);
      PCSrcE = 1'b1; PCTargetE = 32'hFFFF_FFFF;
      #1;
      total++; if (fetch_validF !== 1'b0) $display("FAIL wr_redir_valid got=%b exp=0", fetch_validF); else passed++;
      @(negedge clk);
      PCSrcE = 1'b0;
      #1;
      total++; if (PCounterF !== 32'hFFFF_FFFC) $display("FAIL wr_pc got=%h exp=fffffffc", PCounterF); else passed++;
      total++; if (PCPlus4F !== 32'h0) $display("FAIL wr_pc4 got=%h exp=0", PCPlus4F); else passed++;
      total++; if (instr !== 32'h5A5A_FFFC) $display("FAIL wr_instr got=%h exp=5a5afffc", instr); else passed++;
      @(negedge clk);
      #1;
      total++; if (bus.imem_addr !== 32'h0) $display("FAIL wr_addr got=%h exp=0", bus.imem_addr); else passed++;
      total++; if (instr !== 32'hA5A5_0000) $display("FAIL wr_next_instr got=%h exp=a5a50000", instr); else passed++;
   endtask

   task automatic test_reset_mid_wait;
      reset_dut(2);
      repeat (4) @(negedge clk);
      #1;
      total++; if (PCounterF !== 32'h4) $display("FAIL rw_pre_pc got=%h exp=4", PCounterF); else passed++;
      @(negedge clk);
      rst = 1'b1;
      #1;
      total++; if (fetch_validF !== 1'b0) $display("FAIL rw_rst_valid got=%b exp=0", fetch_validF); else passed++;
      total++; if (PCounterF !== 32'h0) $display("FAIL rw_rst_pc got=%h exp=0", PCounterF); else passed++;
      total++; if (bus.imem_req !== 1'b0) $display("FAIL rw_rst_req got=%b exp=0", bus.imem_req); else passed++;
      @(negedge clk);
      rst = 1'b0;
      #1;
      total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) $display("FAIL rw_req got=%b/%h exp=1/0", bus.imem_req, bus.imem_addr); else passed++;
      @(negedge clk);
      #1;
      total++; if (fetch_validF !== 1'b0) $display("FAIL rw_gap_valid got=%b exp=0", fetch_validF); else passed++;
      @(negedge clk);
      #1;
      total++; if (fetch_validF !== 1'b1 || instr !== 32'hA5A5_0000) $display("FAIL rw_first got=%b/%h exp=1/a5a50000", fetch_validF, instr); else passed++;
      total++; if (PCounterF !== 32'h0) $display("FAIL rw_first_pc got=%h exp=0", PCounterF); else passed++;
   endtask

   initial begin
      rst = 1'b1; stallF = 1'b0; PCSrcE = 1'b0; PCTargetE = '0;
      test_reset();
      test_zero_latency();
      test_latency2();
      test_stall();
      test_redirect_inflight();
      test_redirect_over_stall();
      test_pc_wrap();
      test_reset_mid_wait();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout passed=%0d total=%0d", passed, total);
      $fatal(1);
   end

endmodule
